// File: rtl/mem_access_unit.sv
// MEM-stage access controller: issues word-aligned, byte-lane-strobed requests to a
// variable-latency data memory, extends load data and stalls the pipeline until done.
module mem_access_unit #(
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MemWrite,
   input  logic                 MemToReg,
   input  logic                 Sb,
   input  logic                 Sh,
   input  logic [1:0]           ExtrWord,
   input  logic                 ExtrSigned,
   input  logic [ADDR_BITS-1:0] result_1,
   input  logic [DATA_BITS-1:0] regfile_out2,
   input  logic                 pipe_go,
   output logic                 dm_req,
   output logic                 dm_we,
   output logic [ADDR_BITS-1:0] dm_addr,
   output logic [DATA_BITS-1:0] dm_wdata,
   output logic [3:0]           dm_be,
   input  logic                 dm_ack,
   input  logic [DATA_BITS-1:0] dm_rdata,
   output logic [DATA_BITS-1:0] load_data,
   output logic                 advance,
   output logic                 addr_err
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   logic                 access;
   logic                 store;
   logic                 sz_byte;
   logic                 sz_half;
   logic                 misaligned;
   logic [1:0]           off;
   logic [3:0]           be_next;
   logic [DATA_BITS-1:0] wdata_next;

   logic                 is_load_r;
   logic                 sz_byte_r;
   logic                 sz_half_r;
   logic                 sign_r;
   logic [1:0]           off_r;

   // Shift the addressed lane down to bit 0 and extend it to the full width.
   function automatic logic [DATA_BITS-1:0] extend_load(
      input logic [DATA_BITS-1:0] rdata,
      input logic [1:0]           lane,
      input logic                 byte_sel,
      input logic                 half_sel,
      input logic                 sgn
   );
      logic [DATA_BITS-1:0] shifted;
      extend_load = rdata;
      if (byte_sel) begin
         shifted = rdata >> {lane, 3'b000};
         extend_load = {{(DATA_BITS-8){sgn & shifted[7]}}, shifted[7:0]};
      end else if (half_sel) begin
         shifted = rdata >> {lane[1], 4'b0000};
         extend_load = {{(DATA_BITS-16){sgn & shifted[15]}}, shifted[15:0]};
      end
   endfunction

   always_comb begin
      access     = MemWrite | MemToReg;
      store      = MemWrite;
      off        = result_1[1:0];
      sz_byte    = 1'b0;
      sz_half    = 1'b0;
      be_next    = 4'b1111;
      wdata_next = regfile_out2;
      if (store) begin
         sz_byte = Sb;
         sz_half = !Sb && Sh;
      end else begin
         sz_byte = (ExtrWord == 2'b01);
         sz_half = (ExtrWord == 2'b10);
      end
      misaligned = access && ((sz_half && off[0]) ||
                              (!sz_byte && !sz_half && (off != 2'b00)));
      if (store && sz_byte) begin
         be_next    = 4'b0001 << off;
         wdata_next = {4{regfile_out2[7:0]}};
      end else if (store && sz_half) begin
         be_next    = off[1] ? 4'b1100 : 4'b0011;
         wdata_next = {2{regfile_out2[15:0]}};
      end
   end

   assign addr_err = (state == IDLE) && misaligned;
   assign advance  = ((state == IDLE) && (!access || misaligned)) || (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dm_req    <= 1'b0;
         dm_we     <= 1'b0;
         dm_addr   <= '0;
         dm_wdata  <= '0;
         dm_be     <= 4'b0000;
         load_data <= '0;
         is_load_r <= 1'b0;
         sz_byte_r <= 1'b0;
         sz_half_r <= 1'b0;
         sign_r    <= 1'b0;
         off_r     <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (access && !misaligned) begin
                  dm_req    <= 1'b1;
                  dm_we     <= store;
                  dm_addr   <= {result_1[ADDR_BITS-1:2], 2'b00};
                  dm_wdata  <= wdata_next;
                  dm_be     <= be_next;
                  is_load_r <= !store;
                  sz_byte_r <= sz_byte;
                  sz_half_r <= sz_half;
                  sign_r    <= ExtrSigned;
                  off_r     <= off;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (dm_ack) begin
                  dm_req <= 1'b0;
                  if (is_load_r)
                     load_data <= extend_load(dm_rdata, off_r, sz_byte_r, sz_half_r, sign_r);
                  state <= DONE;
               end
            end
            DONE: begin
               // Hold here until the pipeline actually moves so one access is never issued twice.
               if (pipe_go)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// checked against a lane/extension reference model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemWrite, MemToReg, Sb, Sh, ExtrSigned, pipe_go;
   logic [1:0]  ExtrWord;
   logic [31:0] result_1, regfile_out2;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata, load_data;
   logic [3:0]  dm_be;
   logic        advance, addr_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_load = 32'h0;

   always #5 clk = ~clk;

   mem_access_unit #(.DATA_BITS(32), .ADDR_BITS(32)) dut (
      .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemToReg(MemToReg),
      .Sb(Sb), .Sh(Sh), .ExtrWord(ExtrWord), .ExtrSigned(ExtrSigned),
      .result_1(result_1), .regfile_out2(regfile_out2), .pipe_go(pipe_go),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .load_data(load_data),
      .advance(advance), .addr_err(addr_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      MemWrite = 1'b0; MemToReg = 1'b0; Sb = 1'b0; Sh = 1'b0;
      ExtrWord = 2'b00; ExtrSigned = 1'b0; result_1 = 32'h0; regfile_out2 = 32'h0;
   endtask

   // Present one EX/MEM instruction, play memory with 'lat' wait cycles, and
   // hold pipe_go low for 'go_delay' extra cycles in the completion state.
   task automatic run_access(input logic mw, input logic mr, input logic sb, input logic sh,
                             input logic [1:0] ew, input logic es, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] rdata,
                             input int lat, input int go_delay);
      logic        st, acc, mis, byte_op, half_op;
      logic [3:0]  ebe;
      logic [31:0] ewd, v;
      acc = mw | mr;
      st  = mw;
      if (st) begin
         byte_op = sb; half_op = !sb && sh;
      end else begin
         byte_op = (ew == 2'b01); half_op = (ew == 2'b10);
      end
      mis = acc && (half_op ? (addr % 2 != 0) : (!byte_op && (addr % 4 != 0)));
      ebe = 4'b1111;
      ewd = data;
      if (st && byte_op) begin
         ebe = 4'(1 << (addr % 4));
         ewd = (data & 32'hFF) * 32'h0101_0101;
      end else if (st && half_op) begin
         ebe = ((addr / 2) % 2 != 0) ? 4'b1100 : 4'b0011;
         ewd = (data & 32'hFFFF) * 32'h0001_0001;
      end

      @(posedge clk); #1;
      MemWrite = mw; MemToReg = mr; Sb = sb; Sh = sh; ExtrWord = ew; ExtrSigned = es;
      result_1 = addr; regfile_out2 = data; pipe_go = 1'b0; dm_ack = 1'b0;
      @(negedge clk);
      check_val("addr_err", 32'(addr_err), 32'(mis));
      check_val("advance_c0", 32'(advance), 32'(!acc || mis));
      if (!acc || mis) begin
         check_val("no_req", 32'(dm_req), 32'h0);
         check_val("load_hold", load_data, exp_load);
         return;
      end

      for (int w = 0; w <= lat; w++) begin
         @(posedge clk); #1;
         dm_ack   = (w == lat);
         dm_rdata = (w == lat) ? rdata : $urandom;
         @(negedge clk);
         check_val("req_busy", 32'(dm_req), 32'h1);
         check_val("dm_addr", dm_addr, addr & 32'hFFFF_FFFC);
         check_val("dm_be", 32'(dm_be), 32'(ebe));
         check_val("dm_we", 32'(dm_we), 32'(st));
         check_val("advance_busy", 32'(advance), 32'h0);
         if (st) check_val("dm_wdata", dm_wdata, ewd);
      end

      if (!st) begin
         if (byte_op) begin
            v = (rdata >> (8 * (addr % 4))) & 32'hFF;
            if (es && v[7]) v = v | 32'hFFFF_FF00;
         end else if (half_op) begin
            v = (rdata >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (es && v[15]) v = v | 32'hFFFF_0000;
         end else begin
            v = rdata;
         end
         exp_load = v;
      end

      @(posedge clk); #1;
      dm_ack   = 1'b0;
      dm_rdata = $urandom;
      pipe_go  = (go_delay == 0);
      @(negedge clk);
      check_val("req_done", 32'(dm_req), 32'h0);
      check_val("advance_done", 32'(advance), 32'h1);
      check_val("load_data", load_data, exp_load);
      for (int d = 1; d <= go_delay; d++) begin
         @(posedge clk); #1;
         dm_ack  = 1'($urandom_range(0, 1));
         pipe_go = (d == go_delay);
         @(negedge clk);
         check_val("req_hold", 32'(dm_req), 32'h0);
         check_val("advance_hold", 32'(advance), 32'h1);
         check_val("load_stray_ack", load_data, exp_load);
      end
   endtask

   initial begin
      rst_n = 1'b0; pipe_go = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
      clear_inputs();
      @(negedge clk);
      check_val("rst_req", 32'(dm_req), 32'h0);
      check_val("rst_we", 32'(dm_we), 32'h0);
      check_val("rst_addr", dm_addr, 32'h0);
      check_val("rst_wdata", dm_wdata, 32'h0);
      check_val("rst_be", 32'(dm_be), 32'h0);
      check_val("rst_load", load_data, 32'h0);
      check_val("rst_advance", 32'(advance), 32'h1);
      @(posedge clk); #1 rst_n = 1'b1;

      run_access(1, 0, 0, 0, 2'b00, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
      run_access(1, 0, 1, 0, 2'b00, 0, 32'h103, 32'h0000_00A5, 32'h0, 1, 0);
      run_access(1, 0, 0, 1, 2'b00, 0, 32'h106, 32'h1234_5678, 32'h0, 0, 0);
      run_access(0, 1, 0, 0, 2'b10, 1, 32'h202, 32'h0, 32'h8001_1234, 3, 0);
      check_val("ld_half_signed", load_data, 32'hFFFF_8001);
      run_access(0, 1, 0, 0, 2'b10, 0, 32'h202, 32'h0, 32'h8001_1234, 3, 0);
      check_val("ld_half_unsigned", load_data, 32'h0000_8001);
      run_access(0, 1, 0, 0, 2'b00, 0, 32'h301, 32'h0, 32'hFFFF_FFFF, 0, 0);
      run_access(1, 0, 0, 1, 2'b00, 0, 32'h301, 32'h55AA, 32'h0, 0, 0);
      run_access(0, 1, 0, 0, 2'b01, 1, 32'h303, 32'h0, 32'h80FF_FFFF, 1, 2);
      run_access(1, 1, 0, 0, 2'b00, 0, 32'h400, 32'hCAFE_F00D, 32'h1111_1111, 0, 2);
      run_access(0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0, 0);

      // Reset pulled during BUSY, followed by a stray acknowledge.
      @(posedge clk); #1;
      MemToReg = 1'b1; result_1 = 32'h200; pipe_go = 1'b0;
      @(posedge clk); #1;
      check_val("busy_before_rst", 32'(dm_req), 32'h1);
      rst_n = 1'b0;
      #1;
      check_val("req_async_rst", 32'(dm_req), 32'h0);
      clear_inputs();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1 dm_ack = 1'b0;
      @(negedge clk);
      exp_load = 32'h0;
      check_val("rst_stray_load", load_data, exp_load);
      check_val("rst_stray_req", 32'(dm_req), 32'h0);
      check_val("rst_stray_idle", 32'(advance), 32'h1);

      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = 32'h1000 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0)
            run_access(0, 0, 0, 0, 2'b00, 0, a, $urandom, $urandom, 0, 0);
         else
            run_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       a, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
